// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence generator and its detectors:
// one-hot FSM state encoding and the bit-counter width helper.
package seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_SHIFT = 4'b0010,
    ST_PAR   = 4'b0100,
    ST_GAP   = 4'b1000
  } seq_state_e;

  // Bits needed to count down from w-1 to 0 (never less than one bit).
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/seq_piso_shreg.sv
// W-bit parallel-load, left-shift register; the MSB is the serial output.
module seq_piso_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_en,
  input  logic         shift_en,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] shreg_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)           shreg_q <= '0;
    else if (load_en)  shreg_q <= din;
    else if (shift_en) shreg_q <= {shreg_q[W-2:0], 1'b0};
  end

  assign msb = shreg_q[W-1];

endmodule

// File: rtl/seq_gen_serial.sv
// Parallel-in, serial-out bit-stream generator, MSB first, valid/ready load side.
// Optional even-parity trailer bit when SEQ_GEN_PARITY_EN is defined.
module seq_gen_serial
  import seq_pkg::*;
#(
  parameter int W   = 8,
  parameter int GAP = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [W-1:0] load_data,
  output logic         dout,
  output logic         dout_valid,
  output logic         busy,
  output logic         done,
  output logic [7:0]   word_cnt
);

  localparam int BW = cnt_w(W);
  localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;
`ifdef SEQ_GEN_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  seq_state_e    state_q, state_d;
  logic [BW-1:0] bitcnt_q;
  logic [GW-1:0] gap_q;
  logic          par_q;
  logic          msb;
  logic          accept;

  assign accept = load_valid && load_ready;

  seq_piso_shreg #(.W(W)) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .load_en  (accept),
    .shift_en (state_q == ST_SHIFT),
    .din      (load_data),
    .msb      (msb)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    load_ready = 1'b0;
    done       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        load_ready = 1'b1;
        if (load_valid) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (bitcnt_q == '0) begin
          if (PAR_EN) begin
            state_d = ST_PAR;
          end else begin
            done = 1'b1;
            if (GAP > 0) begin
              state_d = ST_GAP;
            end else begin
              // Last bit doubles as an accept slot so frames run back to back.
              load_ready = 1'b1;
              state_d    = load_valid ? ST_SHIFT : ST_IDLE;
            end
          end
        end
      end
      ST_PAR: begin
        done = 1'b1;
        if (GAP > 0) begin
          state_d = ST_GAP;
        end else begin
          load_ready = 1'b1;
          state_d    = load_valid ? ST_SHIFT : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= '0;
      gap_q    <= '0;
      par_q    <= 1'b0;
      word_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        bitcnt_q <= BW'(W - 1);
        par_q    <= ^load_data;
      end else if (state_q == ST_SHIFT && bitcnt_q != '0) begin
        bitcnt_q <= bitcnt_q - 1'b1;
      end
      if (state_d == ST_GAP && state_q != ST_GAP) gap_q <= GW'(GAP - 1);
      else if (state_q == ST_GAP)                 gap_q <= gap_q - 1'b1;
      if (done) word_cnt <= word_cnt + 8'd1;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign dout_valid = (state_q == ST_SHIFT) || (state_q == ST_PAR);
  assign dout       = (state_q == ST_SHIFT) ? msb :
                      (state_q == ST_PAR)   ? par_q : 1'b0;

endmodule

// File: tb/tb_seq_gen_serial.sv
// Bench for seq_gen_serial: one instance with GAP=1 and one with GAP=0, both
// compared cycle by cycle against a bit-stream model of the expected output.
module tb_seq_gen_serial;

  localparam int W = 8;
`ifdef SEQ_GEN_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME = W + PAR;

  typedef struct packed {
    logic v;
    logic b;
    logic d;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   lv  = '0;
  logic [W-1:0] ld  = '0;
  logic [1:0]   rdy, dq, dv, bsy, dn;
  logic [7:0]   wc [2];

  int   nerr = 0;
  int   nchecks = 0;
  exp_t mq [2][$];
  logic [7:0] mwc [2];
  int   acc [2];
  int   gaps [2] = '{1, 0};
  logic exp_rdy [2];

  bit         hist_en = 1'b0;
  logic [2:0] hist;
  int         hist_n, flags;

  always #5 clk = ~clk;

  seq_gen_serial #(.W(W), .GAP(1)) dut1 (
    .clk(clk), .rst(rst), .load_valid(lv[0]), .load_ready(rdy[0]), .load_data(ld),
    .dout(dq[0]), .dout_valid(dv[0]), .busy(bsy[0]), .done(dn[0]), .word_cnt(wc[0]));

  seq_gen_serial #(.W(W), .GAP(0)) dut0 (
    .clk(clk), .rst(rst), .load_valid(lv[1]), .load_ready(rdy[1]), .load_data(ld),
    .dout(dq[1]), .dout_valid(dv[1]), .busy(bsy[1]), .done(dn[1]), .word_cnt(wc[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input int k, input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) mq[k].push_back('{1'b1, w[i], (i == 0) && (PAR == 0)});
    if (PAR != 0) mq[k].push_back('{1'b1, ^w, 1'b1});
    for (int g = 0; g < gaps[k]; g++) mq[k].push_back('{1'b0, 1'b0, 1'b0});
  endtask

  // Compare the current cycle against the model, then drive inputs for the next edge.
  task automatic step(input logic [1:0] v, input logic [W-1:0] d, input logic r);
    for (int k = 0; k < 2; k++) begin
      exp_t cur;
      cur = (mq[k].size() > 0) ? mq[k][0] : '{1'b0, 1'b0, 1'b0};
      exp_rdy[k] = (mq[k].size() == 0) || (gaps[k] == 0 && mq[k].size() == 1);
      check($sformatf("ready%0d", k), rdy[k], exp_rdy[k]);
      check($sformatf("dout%0d", k), dq[k], cur.b);
      check($sformatf("valid%0d", k), dv[k], cur.v);
      check($sformatf("done%0d", k), dn[k], cur.d);
      check($sformatf("busy%0d", k), bsy[k], mq[k].size() > 0);
      check($sformatf("wcnt%0d", k), wc[k], mwc[k]);
    end
    if (hist_en && dv[0]) begin
      hist = {hist[1:0], dq[0]};
      hist_n++;
      if (hist_n >= 3 && hist == 3'b110) flags++;
    end
    lv = v; ld = d; rst = r;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        mq[k].delete();
        mwc[k] = '0;
        acc[k] = 0;
      end else begin
        if (mq[k].size() > 0) begin
          if (mq[k][0].d) mwc[k] = mwc[k] + 8'd1;
          void'(mq[k].pop_front());
        end
        if (v[k] && exp_rdy[k]) begin
          push_frame(k, d);
          acc[k]++;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      mwc[k] = '0;
      acc[k] = 0;
    end
    repeat (2) @(negedge clk);
    step(2'b00, '0, 1'b1);
    repeat (3) step(2'b00, '0, 1'b0);

    // Directed word 1101_0110 on both instances; count 110 hits on the GAP=1 stream.
    hist = '0; hist_n = 0; flags = 0; hist_en = 1'b1;
    step(2'b11, 8'hD6, 1'b0);
    repeat (FRAME + 4) step(2'b00, '0, 1'b0);
    hist_en = 1'b0;
    check("flags110", flags, 2);

    // FF then 00 with valid held: back to back on the GAP=0 instance.
    step(2'b11, 8'hFF, 1'b0);
    repeat (FRAME) step(2'b11, 8'h00, 1'b0);
    repeat (FRAME + 4) step(2'b00, '0, 1'b0);

    // Random traffic; data changes every cycle, including while busy.
    for (int i = 0; i < 800; i++) begin
      logic [1:0] v;
      v[0] = ($urandom_range(0, 99) < 60);
      v[1] = ($urandom_range(0, 99) < 60);
      step(v, W'($urandom), ($urandom_range(0, 199) == 0));
    end
    repeat (FRAME + 4) step(2'b00, '0, 1'b0);

    // Reset landing on the 4th bit of a frame.
    step(2'b11, 8'hA5, 1'b0);
    repeat (3) step(2'b00, '0, 1'b0);
    step(2'b00, '0, 1'b1);
    step(2'b00, '0, 1'b0);

    // 256 words on each instance: the word counter must wrap to zero.
    step(2'b00, '0, 1'b1);
    for (int n = 0; n < 4000; n++) begin
      if (acc[0] >= 256 && acc[1] >= 256 && mq[0].size() == 0 && mq[1].size() == 0) break;
      step({acc[1] < 256, acc[0] < 256}, W'($urandom), 1'b0);
    end
    check("acc1", acc[0], 256);
    check("acc0", acc[1], 256);
    check("wrap1", wc[0], 8'd0);
    check("wrap0", wc[1], 8'd0);
    step(2'b00, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
